gbc_catc: RTL and testbench
===========================

Name: gbc_catc

Overview:
- Clock-adjusted timing controller directly upstream of the GBC cartridge controller and core.
- Takes the console reference tick (ClkEn) and the memory-path stall (Delay = ~(Ready & DataReady)), and produces the gated core tick ClkEnOut.
- Ticks withheld during a stall are counted as debt and repaid later as extra ticks on idle core-clock cycles, so emulated time catches back up to wall time.

Parameters:
- DebtWidth, 8, width of the owed-tick counter.
- MaxDebt, 255, saturation limit for debt; must be ≤ 2^DebtWidth-1.
- CatchupSpacing, 2, minimum core-clock cycles between consecutive ClkEnOut pulses when the later one is a catch-up pulse; must be ≥ 1.

Ports:
- Clk  input  1  core system clock; all logic on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- ClkEn  input  1  console reference tick, single-cycle pulses.
- Delay  input  1  stall request from the memory/cartridge path.
- ClkEnOut  output  1  core tick, single-cycle pulse, registered.
- Debt  output  DebtWidth  current owed-tick count.
- Behind  output  1  high while Debt != 0.
- Overflow  output  1  sticky; set when a tick is lost because debt is saturated.

Behaviour:
- Reset (sync, active-high) clears ClkEnOut=0, Debt=0, Behind=0, Overflow=0, and sets the spacing counter to CatchupSpacing (saturated). Reset takes priority over all other inputs in the same cycle.
- All outputs are registered. A decision made from inputs sampled at edge N appears on ClkEnOut after edge N, i.e. 1-cycle latency.
- State is implied by Debt:
  - RUN: Debt == 0.
  - BEHIND: Debt > 0.
  - RUN→BEHIND when a tick is withheld. BEHIND→RUN when the last catch-up pulse issues.
- Per-cycle decision, evaluated in this priority order:
  1. Delay=1 and ClkEn=1: no pulse. If Debt < MaxDebt, Debt += 1; else Debt holds and Overflow is set to 1.
  2. Delay=1 and ClkEn=0: no pulse; Debt holds.
  3. Delay=0 and ClkEn=1: native pulse; Debt unchanged. Spacing is ignored for native pulses.
  4. Delay=0, ClkEn=0, Debt > 0, and spacing satisfied: catch-up pulse; Debt -= 1.
  5. Otherwise: no pulse.
- At most one ClkEnOut pulse per cycle. A native tick arriving while in BEHIND does not repay debt.
- Spacing counter:
  - Cleared to 0 on every issued pulse.
  - Otherwise increments, saturating at CatchupSpacing.
  - "Spacing satisfied" means counter + 1 ≥ CatchupSpacing. With CatchupSpacing=1, back-to-back pulses are allowed.
- Delay blocks catch-up pulses as well as native ones; debt never decreases while Delay=1.
- Debt never wraps. Increment saturates at MaxDebt; decrement only occurs when Debt > 0.
- Behind is registered alongside Debt and always equals (Debt != 0).
- Overflow clears only on Reset.

Optional Feature:
- Macro: GBC_CATC_STATS_EN.
- Defined: adds output StallTicks [15:0], a saturating count of all ClkEn ticks received with Delay=1 (including those lost at saturation).
  - Reset to 0. Holds at 16'hFFFF once reached.
  - Updates on the same edge as Debt.
- Undefined: the StallTicks port and its counter are absent. All other behaviour is identical.

Test Plan:
- ClkEn pulse every 4 cycles, Delay=0, for 10 ticks -> 10 ClkEnOut pulses, each 1 cycle after its ClkEn; Debt stays 0; Behind=0.
- Delay=1 across 3 ClkEn ticks, then Delay=0, CatchupSpacing=2, ClkEn period 8 -> Debt reaches 3; then catch-up pulses on every 2nd idle cycle; Debt goes 3→2→1→0; Behind falls with the last pulse; no pulse is ever emitted while Delay=1.
- Debt=2, then ClkEn arrives on a cycle where catch-up is also eligible -> exactly one pulse that cycle (native); Debt remains 2; catch-up resumes after spacing is satisfied.
- MaxDebt=4, Delay=1 for 6 ClkEn ticks -> Debt saturates at 4; Overflow=1 on the 5th tick and stays 1 after debt drains to 0.
- Reset asserted with Debt=3 and Overflow=1, simultaneous with ClkEn=1 and Delay=0 -> next cycle ClkEnOut=0, Debt=0, Behind=0, Overflow=0.
- With GBC_CATC_STATS_EN: 7 stalled ClkEn ticks (MaxDebt=4) -> StallTicks=7 while Debt=4; without the macro, the build elaborates with no StallTicks port.

Source files
------------

// File: rtl/gbc_catc.sv
// Catch-up timing controller: gates the reference tick with the memory stall and
// repays withheld ticks later. Optional StallTicks statistic under GBC_CATC_STATS_EN.
module gbc_catc #(
    parameter int unsigned DebtWidth      = 8,
    parameter int unsigned MaxDebt        = 255,
    parameter int unsigned CatchupSpacing = 2
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 ClkEn,
    input  logic                 Delay,
    output logic                 ClkEnOut,
    output logic [DebtWidth-1:0] Debt,
    output logic                 Behind,
`ifdef GBC_CATC_STATS_EN
    output logic [15:0]          StallTicks,
`endif
    output logic                 Overflow
);

    localparam int unsigned SpcW = $clog2(CatchupSpacing + 1);
    localparam logic [SpcW-1:0]      SpcMax  = SpcW'(CatchupSpacing);
    localparam logic [SpcW-1:0]      SpcNeed = SpcW'(CatchupSpacing - 1);
    localparam logic [DebtWidth-1:0] DebtMax = DebtWidth'(MaxDebt);

    typedef enum logic {
        ST_RUN,
        ST_BEHIND
    } state_t;

    state_t               state_q, state_d;
    logic                 clk_en_out_q, clk_en_out_d;
    logic [DebtWidth-1:0] debt_q, debt_d;
    logic                 overflow_q, overflow_d;
    logic [SpcW-1:0]      spc_q, spc_d;
    logic                 spc_ok;

    // Counter counts cycles since the last pulse, so "+1 >= spacing" becomes ">= spacing-1".
    assign spc_ok = (spc_q >= SpcNeed);

    always_comb begin
        clk_en_out_d = 1'b0;
        debt_d       = debt_q;
        overflow_d   = overflow_q;

        if (Delay) begin
            if (ClkEn) begin
                if (debt_q < DebtMax) begin
                    debt_d = debt_q + 1'b1;
                end else begin
                    overflow_d = 1'b1;
                end
            end
        end else if (ClkEn) begin
            clk_en_out_d = 1'b1;
        end else if (state_q == ST_BEHIND && spc_ok) begin
            clk_en_out_d = 1'b1;
            debt_d       = debt_q - 1'b1;
        end

        if (clk_en_out_d) begin
            spc_d = '0;
        end else if (spc_q < SpcMax) begin
            spc_d = spc_q + 1'b1;
        end else begin
            spc_d = spc_q;
        end

        state_d = (debt_d != '0) ? ST_BEHIND : ST_RUN;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= ST_RUN;
            clk_en_out_q <= 1'b0;
            debt_q       <= '0;
            overflow_q   <= 1'b0;
            spc_q        <= SpcMax;
        end else begin
            state_q      <= state_d;
            clk_en_out_q <= clk_en_out_d;
            debt_q       <= debt_d;
            overflow_q   <= overflow_d;
            spc_q        <= spc_d;
        end
    end

    assign ClkEnOut = clk_en_out_q;
    assign Debt     = debt_q;
    assign Behind   = (state_q == ST_BEHIND);
    assign Overflow = overflow_q;

`ifdef GBC_CATC_STATS_EN
    logic [15:0] stall_ticks_q, stall_ticks_d;

    always_comb begin
        stall_ticks_d = stall_ticks_q;
        if (Delay && ClkEn && stall_ticks_q != '1) begin
            stall_ticks_d = stall_ticks_q + 16'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            stall_ticks_q <= '0;
        end else begin
            stall_ticks_q <= stall_ticks_d;
        end
    end

    assign StallTicks = stall_ticks_q;
`endif

endmodule

// File: tb/tb_gbc_catc.sv
// Directed, table-driven bench for gbc_catc (MaxDebt=4, CatchupSpacing=2).
module tb_gbc_catc;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       ClkEn = 1'b0;
    logic       Delay = 1'b0;
    logic       ClkEnOut;
    logic [7:0] Debt;
    logic       Behind;
    logic       Overflow;
    logic [15:0] stall_ticks;

    int checks = 0;
    int errors = 0;

    gbc_catc #(
        .DebtWidth(8),
        .MaxDebt(4),
        .CatchupSpacing(2)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .ClkEn(ClkEn),
        .Delay(Delay),
        .ClkEnOut(ClkEnOut),
        .Debt(Debt),
        .Behind(Behind),
`ifdef GBC_CATC_STATS_EN
        .StallTicks(stall_ticks),
`endif
        .Overflow(Overflow)
    );

`ifndef GBC_CATC_STATS_EN
    assign stall_ticks = '0;
`endif

    always #5 Clk = ~Clk;

    typedef struct {
        logic       rst;
        logic       ce;
        logic       dl;
        logic       out;
        logic [7:0] debt;
        logic       behind;
        logic       ovf;
        int         stall;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic c, input logic d, input logic o,
                       input int db, input logic b, input logic ov, input int st);
        vec_t v;
        v.rst = r; v.ce = c; v.dl = d; v.out = o;
        v.debt = 8'(db); v.behind = b; v.ovf = ov; v.stall = st;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic c, input logic d);
        @(negedge Clk);
        Reset = r; ClkEn = c; Delay = d;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        int pulses;
        int cyc;
        string tag;

        // rst ce dl | out debt behind ovf stall
        add(1,0,0, 0,0,0,0, 0);   // reset
        add(0,1,0, 1,0,0,0, 0);   // native tick
        add(0,0,0, 0,0,0,0, 0);
        add(0,1,1, 0,1,1,0, 1);   // withheld ticks build debt
        add(0,0,1, 0,1,1,0, 1);   // Delay blocks catch-up
        add(0,1,1, 0,2,1,0, 2);
        add(0,0,1, 0,2,1,0, 2);
        add(0,1,1, 0,3,1,0, 3);
        add(0,0,0, 1,2,1,0, 3);   // catch-up every 2nd idle cycle
        add(0,0,0, 0,2,1,0, 3);
        add(0,0,0, 1,1,1,0, 3);
        add(0,0,0, 0,1,1,0, 3);
        add(0,0,0, 1,0,0,0, 3);   // last repayment drops Behind
        add(0,0,0, 0,0,0,0, 3);
        add(0,1,1, 0,1,1,0, 4);
        add(0,1,1, 0,2,1,0, 5);
        add(0,1,0, 1,2,1,0, 5);   // native beats catch-up, no repayment
        add(0,0,0, 0,2,1,0, 5);   // spacing not yet satisfied
        add(0,0,0, 1,1,1,0, 5);
        add(0,1,0, 1,1,1,0, 5);   // native ignores spacing
        add(0,0,0, 0,1,1,0, 5);
        add(0,0,0, 1,0,0,0, 5);
        add(0,1,1, 0,1,1,0, 6);   // saturation at MaxDebt=4
        add(0,1,1, 0,2,1,0, 7);
        add(0,1,1, 0,3,1,0, 8);
        add(0,1,1, 0,4,1,0, 9);
        add(0,1,1, 0,4,1,1, 10);  // 5th tick lost -> Overflow
        add(0,1,1, 0,4,1,1, 11);
        add(0,0,0, 1,3,1,1, 11);
        add(0,0,0, 0,3,1,1, 11);
        add(0,0,0, 1,2,1,1, 11);
        add(0,0,0, 0,2,1,1, 11);
        add(0,0,0, 1,1,1,1, 11);
        add(0,0,0, 0,1,1,1, 11);
        add(0,0,0, 1,0,0,1, 11);  // Overflow stays sticky
        add(0,0,0, 0,0,0,1, 11);
        add(0,1,1, 0,1,1,1, 12);
        add(0,1,1, 0,2,1,1, 13);
        add(0,1,1, 0,3,1,1, 14);
        add(1,1,0, 0,0,0,0, 0);   // reset wins over native tick
        add(0,0,0, 0,0,0,0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].ce, vecs[i].dl);
            tag = $sformatf("v%0d", i);
            check({tag, ".out"},    int'(ClkEnOut), int'(vecs[i].out));
            check({tag, ".debt"},   int'(Debt),     int'(vecs[i].debt));
            check({tag, ".behind"}, int'(Behind),   int'(vecs[i].behind));
            check({tag, ".ovf"},    int'(Overflow), int'(vecs[i].ovf));
`ifdef GBC_CATC_STATS_EN
            check({tag, ".stall"},  int'(stall_ticks), vecs[i].stall);
`endif
        end

        // Ten native ticks, period 4: each pass-through appears one cycle later.
        for (int t = 0; t < 10; t++) begin
            for (int p = 0; p < 4; p++) begin
                step(1'b0, (p == 0), 1'b0);
                check($sformatf("nat%0d_%0d.out", t, p), int'(ClkEnOut), (p == 0) ? 1 : 0);
                check($sformatf("nat%0d_%0d.debt", t, p), int'(Debt), 0);
            end
        end
        check("nat.behind", int'(Behind), 0);

        // Seven stalled ticks saturate debt at 4 and all count as stalls.
        for (int t = 0; t < 7; t++) begin
            step(1'b0, 1'b1, 1'b1);
            check($sformatf("stall%0d.out", t), int'(ClkEnOut), 0);
        end
        check("sat.debt", int'(Debt), 4);
        check("sat.ovf", int'(Overflow), 1);
`ifdef GBC_CATC_STATS_EN
        check("sat.stall", int'(stall_ticks), 7);
`endif

        // Drain with a bounded wait: exactly four catch-up pulses.
        pulses = 0;
        cyc = 0;
        while (Behind && cyc < 20) begin
            step(1'b0, 1'b0, 1'b0);
            if (ClkEnOut) pulses++;
            cyc++;
        end
        check("drain.timeout", int'(Behind), 0);
        check("drain.pulses", pulses, 4);
        check("drain.cycles", cyc, 7);
        check("drain.ovf", int'(Overflow), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
